event_accumulator: RTL and testbench
====================================

EVENT_ACCUMULATOR -- requirements
Module: event_accumulator

Interface
REQ-001 SHALL have parameter CNT_W, default 4: width of the pending-event counter; legal range 2..8.
REQ-002 SHALL have parameter SEQ_W, default 8: width of the delivered-event sequence tag.
REQ-003 SHALL have port clk_b  input  1  destination-domain clock; the only clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sig_b  input  1  synchronized event pulse; each clk_b cycle sampled high is one event.
REQ-006 SHALL have port ack  input  1  consumer accepts the offered event when high together with req.
REQ-007 SHALL have port clr_ovf  input  1  clears the sticky overflow flag.
REQ-008 SHALL have port req  output  1  at least one event pending; registered.
REQ-009 SHALL have port seq  output  SEQ_W  tag of the event currently offered; registered.
REQ-010 SHALL have port pending  output  CNT_W  number of queued events; registered.
REQ-011 SHALL have port ovf  output  1  sticky: one or more events dropped; registered.

Function
REQ-012 SHALL define inc = sig_b AND NOT (pending = MAX AND NOT xfer), xfer = req AND ack, MAX = 2^CNT_W-1.
REQ-013 SHALL update pending each cycle: +1 on inc only; -1 on xfer only; unchanged on both or neither.
REQ-014 SHALL implement two states: IDLE (pending = 0, req = 0) and PEND (pending > 0, req = 1).
REQ-015 SHALL move IDLE->PEND on the edge sampling sig_b = 1; req rises exactly one cycle after the sampled pulse.
REQ-016 SHALL move PEND->IDLE only when xfer occurs with pending = 1 and sig_b = 0.
REQ-017 SHALL stay in PEND when xfer and sig_b coincide at pending = 1; req does not drop.
REQ-018 SHALL ignore ack while req = 0; no state, count or seq change.
REQ-019 SHALL increment seq by 1 modulo 2^SEQ_W on every xfer; seq wraps from all-ones to 0 without a flag.
REQ-020 SHALL, with pending = MAX, no xfer and sig_b = 1, drop the event, hold pending at MAX and set ovf on that edge.
REQ-021 SHALL accept sig_b at pending = MAX when xfer occurs in the same cycle (net zero); ovf is not set.
REQ-022 SHALL clear ovf on the edge sampling clr_ovf = 1, unless a drop occurs in the same cycle; then ovf stays 1 (set wins).
REQ-023 SHALL never let pending wrap: no increment past MAX and no decrement below 0.

Reset
REQ-024 SHALL, while rst_n = 0, force req = 0, seq = 0, pending = 0, ovf = 0 and state IDLE, independent of clk_b.
REQ-025 SHALL discard all queued events on reset, including mid-handshake; no transfer completes on the releasing edge.
REQ-026 SHALL begin sampling sig_b on the first rising clk_b edge after rst_n deasserts.

Structure
REQ-027 SHALL place the state enumeration (IDLE, PEND) and the default CNT_W/SEQ_W constants in a shared package.
REQ-028 SHALL instantiate one sub-module, sat_updown_counter (CNT_W, inc/dec in, count/at_max out); all other logic is inline.
REQ-029 SHALL sit directly downstream of the toggle synchronizer, with sig_b connected straight to its output and no extra flops.

Verification
REQ-030 SHALL cover a single pulse: sig_b high one cycle -> req = 1, pending = 1, seq = 0 next cycle; ack for one cycle -> req = 0, seq = 1.
REQ-031 SHALL cover a burst: 5 consecutive sig_b cycles, ack = 0 -> pending = 5; then ack held high -> 5 transfers, seq = 5, req low after the fifth.
REQ-032 SHALL cover overflow (CNT_W = 4): 17 pulses, ack = 0 -> pending = 15, ovf = 1; clr_ovf pulse -> ovf = 0, pending still 15.
REQ-033 SHALL cover coincidence: pending = 1, sig_b and ack high in the same cycle -> pending = 1, req stays 1, seq +1.
REQ-034 SHALL cover mid-handshake reset: pending = 3, ack high, rst_n pulsed low -> all outputs 0 asynchronously; first post-reset pulse -> seq = 0 offered.
REQ-035 SHALL cover seq wrap (SEQ_W = 8): 256 transfers -> seq returns to 0 with no ovf.

Source files
------------

// File: rtl/event_accumulator_pkg.sv
// Shared constants and state encoding for the event accumulator slice.
package event_accumulator_pkg;

  localparam int DEFAULT_CNT_W = 4;
  localparam int DEFAULT_SEQ_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

endpackage

// File: rtl/event_accumulator_sat_updown_counter.sv
// Saturating up/down counter: never wraps past all-ones or below zero.
module sat_updown_counter
  import event_accumulator_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MAX = '1;

  assign at_max = (count == MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && !at_max) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/event_accumulator.sv
// Queues synchronized event pulses and offers them one at a time over a req/ack handshake.
module event_accumulator
  import event_accumulator_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W,
  parameter int SEQ_W = DEFAULT_SEQ_W
) (
  input  logic             clk_b,
  input  logic             rst_n,
  input  logic             sig_b,
  input  logic             ack,
  input  logic             clr_ovf,
  output logic             req,
  output logic [SEQ_W-1:0] seq,
  output logic [CNT_W-1:0] pending,
  output logic             ovf
);

  state_t state, state_next;
  logic   xfer;
  logic   inc;
  logic   drop;
  logic   at_max;
  logic   last_one;

  // req is decoded straight from the state flop, so it is glitch-free and registered.
  assign req      = (state == PEND);
  assign xfer     = req & ack;
  assign inc      = sig_b & ~(at_max & ~xfer);
  assign drop     = sig_b & at_max & ~xfer;
  assign last_one = (pending == CNT_W'(1));

  sat_updown_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk   (clk_b),
    .rst_n (rst_n),
    .inc   (inc),
    .dec   (xfer),
    .count (pending),
    .at_max(at_max)
  );

  // NOTE: next-state is defaulted first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (sig_b) state_next = PEND;
      PEND: if (xfer && last_one && !sig_b) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      seq   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      if (xfer) seq <= seq + SEQ_W'(1);
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_event_accumulator.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic against a behavioural model.
module tb_event_accumulator;

  localparam int CNT_W = 4;
  localparam int SEQ_W = 8;
  localparam int MAX   = (1 << CNT_W) - 1;
  localparam int SEQ_M = 1 << SEQ_W;

  logic             clk_b = 1'b0;
  logic             rst_n;
  logic             sig_b;
  logic             ack;
  logic             clr_ovf;
  logic             req;
  logic [SEQ_W-1:0] seq;
  logic [CNT_W-1:0] pending;
  logic             ovf;

  int tests = 0;
  int fails = 0;

  // Behavioural model: a count of queued events, a tag and a sticky flag.
  int m_pending = 0;
  int m_seq     = 0;
  int m_ovf     = 0;

  event_accumulator #(
    .CNT_W(CNT_W),
    .SEQ_W(SEQ_W)
  ) dut (
    .clk_b  (clk_b),
    .rst_n  (rst_n),
    .sig_b  (sig_b),
    .ack    (ack),
    .clr_ovf(clr_ovf),
    .req    (req),
    .seq    (seq),
    .pending(pending),
    .ovf    (ovf)
  );

  always #5 clk_b = ~clk_b;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      m_pending = 0;
      m_seq     = 0;
      m_ovf     = 0;
    end else begin
      automatic bit x    = (m_pending > 0) && ack;
      automatic bit take = sig_b && ((m_pending < MAX) || x);
      automatic bit lost = sig_b && !take;
      m_pending = m_pending + int'(take) - int'(x);
      if (x) m_seq = (m_seq + 1) % SEQ_M;
      if (lost)         m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
  end

  always @(negedge clk_b) begin
    check("cyc_req",     int'(req),     int'(m_pending > 0));
    check("cyc_pending", int'(pending), m_pending);
    check("cyc_seq",     int'(seq),     m_seq);
    check("cyc_ovf",     int'(ovf),     m_ovf);
  end

  task automatic step(input logic s, input logic a, input logic c);
    sig_b   = s;
    ack     = a;
    clr_ovf = c;
    @(posedge clk_b);
    #1;
  endtask

  task automatic expect_out(input string tag, input int e_req, input int e_pend,
                            input int e_seq, input int e_ovf);
    check({tag, "_req"},     int'(req),     e_req);
    check({tag, "_pending"}, int'(pending), e_pend);
    check({tag, "_seq"},     int'(seq),     e_seq);
    check({tag, "_ovf"},     int'(ovf),     e_ovf);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; sig_b = 1'b0; ack = 1'b0; clr_ovf = 1'b0;
    #3;
    expect_out("reset", 0, 0, 0, 0);
    @(posedge clk_b); #1;
    rst_n = 1'b1;

    // Single pulse, then an ack with nothing pending is ignored.
    step(1, 0, 0); expect_out("single_offer", 1, 1, 0, 0);
    step(0, 1, 0); expect_out("single_take",  0, 0, 1, 0);
    step(0, 1, 0); expect_out("idle_ack",     0, 0, 1, 0);

    // Burst of five, then drained by a held ack.
    repeat (5) step(1, 0, 0);
    expect_out("burst_fill", 1, 5, 1, 0);
    repeat (4) step(0, 1, 0);
    expect_out("burst_4", 1, 1, 5, 0);
    step(0, 1, 0);
    expect_out("burst_done", 0, 0, 6, 0);

    // Overflow, clear, set-wins, and accept-at-max with a transfer.
    repeat (17) step(1, 0, 0);
    expect_out("ovf_set", 1, 15, 6, 1);
    step(0, 0, 1); expect_out("ovf_clr",      1, 15, 6, 0);
    step(1, 0, 1); expect_out("ovf_set_wins", 1, 15, 6, 1);
    step(0, 0, 1); expect_out("ovf_clr2",     1, 15, 6, 0);
    step(1, 1, 0); expect_out("max_net_zero", 1, 15, 7, 0);
    repeat (15) step(0, 1, 0);
    expect_out("drain", 0, 0, 22, 0);

    // Coincident pulse and transfer at pending = 1.
    step(1, 0, 0); expect_out("coin_fill", 1, 1, 22, 0);
    step(1, 1, 0); expect_out("coin_both", 1, 1, 23, 0);
    step(0, 1, 0); expect_out("coin_end",  0, 0, 24, 0);

    // Reset asserted mid-handshake.
    repeat (3) step(1, 0, 0);
    sig_b = 1'b0; ack = 1'b1;
    #1 rst_n = 1'b0;
    #1 expect_out("async_rst", 0, 0, 0, 0);
    @(posedge clk_b); #1;
    rst_n = 1'b1;
    step(0, 1, 0); expect_out("post_rst_ack",   0, 0, 0, 0);
    step(1, 0, 0); expect_out("post_rst_pulse", 1, 1, 0, 0);
    step(0, 1, 0);

    // 256 transfers wrap the tag back to its start value.
    step(1, 0, 0);
    repeat (255) step(1, 1, 0);
    step(0, 1, 0);
    expect_out("seq_wrap", 0, 0, 1, 0);

    // Randomized traffic in phases biased toward filling, draining and mixing.
    for (int ph = 0; ph < 12; ph++) begin
      for (int i = 0; i < 150; i++) begin
        automatic int p_sig = (ph % 3 == 0) ? 90 : (ph % 3 == 1) ? 20 : 50;
        automatic int p_ack = (ph % 3 == 0) ? 10 : (ph % 3 == 1) ? 80 : 50;
        step(($urandom_range(99) < p_sig), ($urandom_range(99) < p_ack),
             ($urandom_range(99) < 5));
      end
    end

    step(0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
